// File: rtl/dmem_port_ctrl_if.sv
// rtl/dmem_port_ctrl_if.sv - MEM-stage, debug-dump and memory-port signal bundle for dmem_port_ctrl
// o_addr_err exists only when DMEM_ADDR_CHECK_EN is defined.
interface dmem_port_ctrl_if #(
    parameter int NBITS = 32
);
    logic             i_step;
    logic             i_mem_read;
    logic             i_mem_write;
    logic [NBITS-1:0] i_alu_address;
    logic [NBITS-1:0] i_data_reg;
    logic [NBITS-1:0] o_data_read;
    logic             o_stall;
    logic             i_dump_start;
    logic [NBITS-1:0] o_dump_data;
    logic [NBITS-1:0] o_dump_addr;
    logic             o_dump_valid;
    logic             i_dump_ready;
    logic             o_dump_busy;
    logic             o_dump_done;
    logic [NBITS-1:0] o_mem_addr;
    logic [NBITS-1:0] o_mem_wdata;
    logic             o_mem_we;
    logic             o_mem_re;
    logic [NBITS-1:0] i_mem_rdata;
`ifdef DMEM_ADDR_CHECK_EN
    logic             o_addr_err;
`endif

    modport slave (
        input  i_step, i_mem_read, i_mem_write, i_alu_address, i_data_reg,
        input  i_dump_start, i_dump_ready, i_mem_rdata,
`ifdef DMEM_ADDR_CHECK_EN
        output o_addr_err,
`endif
        output o_data_read, o_stall, o_dump_data, o_dump_addr, o_dump_valid,
        output o_dump_busy, o_dump_done, o_mem_addr, o_mem_wdata, o_mem_we, o_mem_re
    );

    modport master (
        output i_step, i_mem_read, i_mem_write, i_alu_address, i_data_reg,
        output i_dump_start, i_dump_ready, i_mem_rdata,
`ifdef DMEM_ADDR_CHECK_EN
        input  o_addr_err,
`endif
        input  o_data_read, o_stall, o_dump_data, o_dump_addr, o_dump_valid,
        input  o_dump_busy, o_dump_done, o_mem_addr, o_mem_wdata, o_mem_we, o_mem_re
    );
endinterface

// File: rtl/dmem_port_ctrl.sv
// rtl/dmem_port_ctrl.sv - data-memory port shared between the MEM stage and the debug dump engine
// Define DMEM_ADDR_CHECK_EN to suppress and flag pipeline accesses at or beyond TAM.
module dmem_port_ctrl #(
    parameter int NBITS = 32,
    parameter int TAM   = 16
) (
    input  logic            i_clk,
    input  logic            i_reset,
    dmem_port_ctrl_if.slave bus
);
    localparam int AW = (TAM > 1) ? $clog2(TAM) : 1;

    typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_OUT, S_DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic             pending;
    logic             rd_pend;
    logic [AW-1:0]    cnt;
    logic             dump_valid_q;
    logic [NBITS-1:0] dump_data_q;
    logic [NBITS-1:0] dump_addr_q;

    logic             req;
    logic             pa;
    logic             dump_go;
    logic             handshake;
    logic             last_word;
    logic             in_range;
    logic             pipe_rd;
    logic [NBITS-1:0] pipe_addr;

    assign req       = bus.i_step & (bus.i_mem_read | bus.i_mem_write);
    assign pa        = req & (state == S_IDLE);
    // A start pulse may launch the dump in its own cycle; the pipeline always wins the port.
    assign dump_go   = (pending | bus.i_dump_start) & ~pa;
    assign handshake = (state == S_OUT) & dump_valid_q & bus.i_dump_ready;
    assign last_word = (cnt == AW'(TAM - 1));
    assign pipe_rd   = pa & bus.i_mem_read & ~bus.i_mem_write & in_range;

`ifdef DMEM_ADDR_CHECK_EN
    assign in_range  = (bus.i_alu_address < NBITS'(TAM));
    assign pipe_addr = bus.i_alu_address;
`else
    logic unused_addr_hi;
    assign in_range       = 1'b1;
    assign pipe_addr      = NBITS'(bus.i_alu_address[AW-1:0]);
    assign unused_addr_hi = ^bus.i_alu_address[NBITS-1:AW];
`endif

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (dump_go) state_nxt = S_RD;
            S_RD:    state_nxt = S_WAIT;
            S_WAIT:  state_nxt = S_OUT;
            S_OUT:   if (handshake) state_nxt = last_word ? S_DONE : S_RD;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.o_mem_addr   = (state == S_RD) ? NBITS'(cnt) : pipe_addr;
        bus.o_mem_wdata  = bus.i_data_reg;
        bus.o_mem_we     = pa & bus.i_mem_write & in_range;
        bus.o_mem_re     = (state == S_RD) | pipe_rd;
        bus.o_stall      = req & (state != S_IDLE);
        bus.o_data_read  = rd_pend ? bus.i_mem_rdata : '0;
        bus.o_dump_valid = dump_valid_q;
        bus.o_dump_data  = dump_data_q;
        bus.o_dump_addr  = dump_addr_q;
        bus.o_dump_busy  = pending | (state != S_IDLE);
        bus.o_dump_done  = (state == S_DONE);
`ifdef DMEM_ADDR_CHECK_EN
        bus.o_addr_err   = pa & ~in_range;
`endif
    end

    // Start pulses are only latched while idle, so a running dump ignores them.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            pending      <= 1'b0;
            rd_pend      <= 1'b0;
            cnt          <= '0;
            dump_valid_q <= 1'b0;
            dump_data_q  <= '0;
            dump_addr_q  <= '0;
        end else begin
            rd_pend <= pipe_rd;
            if (state == S_IDLE) begin
                if (dump_go) begin
                    pending <= 1'b0;
                    cnt     <= '0;
                end else if (bus.i_dump_start) begin
                    pending <= 1'b1;
                end
            end
            if (state == S_WAIT) begin
                dump_valid_q <= 1'b1;
                dump_data_q  <= bus.i_mem_rdata;
                dump_addr_q  <= NBITS'(cnt);
            end else if (handshake) begin
                dump_valid_q <= 1'b0;
                if (!last_word) cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_dmem_port_ctrl.sv
// tb/tb_dmem_port_ctrl.sv - self-checking bench for dmem_port_ctrl with a behavioural 1-cycle memory
module tb_dmem_port_ctrl;
    localparam int NBITS = 32;
    localparam int TAM   = 16;

    typedef struct {
        logic        step, rd, wr;
        logic [31:0] addr, wdata;
        logic        exp_we, exp_re, exp_err;
        logic [31:0] exp_addr;
    } vec_t;

    typedef struct {
        logic [31:0] addr, data;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n;
    logic reload;
    logic [NBITS-1:0] mem   [TAM];
    logic [NBITS-1:0] model [TAM];
    beat_t       sb_dump[$];
    logic [31:0] sb_rd[$];
    vec_t        vecs[10];
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_port_ctrl_if #(.NBITS(NBITS)) bus();

    dmem_port_ctrl #(.NBITS(NBITS), .TAM(TAM)) dut (
        .i_clk  (clk),
        .i_reset(rst_n),
        .bus    (bus)
    );

    always @(posedge clk) begin
        if (reload) begin
            for (int i = 0; i < TAM; i++) mem[i] <= NBITS'(i);
        end else if (bus.o_mem_we) begin
            mem[bus.o_mem_addr[3:0]] <= bus.o_mem_wdata;
        end
        if (bus.o_mem_re) bus.i_mem_rdata <= mem[bus.o_mem_addr[3:0]];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic step, input logic rd, input logic wr,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic ewe, input logic ere, input logic eerr,
                                input logic [31:0] eaddr);
        vec_t v;
        v.step = step; v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
        v.exp_we = ewe; v.exp_re = ere; v.exp_err = eerr; v.exp_addr = eaddr;
        return v;
    endfunction

    task automatic clear_pipe();
        bus.i_step = 0; bus.i_mem_read = 0; bus.i_mem_write = 0;
        bus.i_alu_address = '0; bus.i_data_reg = '0;
    endtask

    task automatic do_reload();
        reload = 1;
        tick();
        reload = 0;
        for (int i = 0; i < TAM; i++) model[i] = 32'(i);
    endtask

    task automatic push_dump();
        beat_t b;
        for (int i = 0; i < TAM; i++) begin
            b.addr = 32'(i);
            b.data = model[i];
            sb_dump.push_back(b);
        end
    endtask

    // Runs one dump to completion; n counts cycles after the caller's last tick.
    task automatic run_dump(input int hold_beat, input int exp_done, input bit probe);
        int    done_cnt = 0;
        int    held     = 0;
        beat_t b;
        bus.i_dump_ready = 1;
        for (int n = 1; n <= exp_done + 4; n++) begin
            tick();
            bus.i_dump_start = 0;
            if (probe && n == 10) begin
                bus.i_step = 1; bus.i_mem_read = 1; bus.i_alu_address = 32'd9;
                #1;
                check("stall_rd", 32'(bus.o_stall), 32'd1);
                check("dump_re_rd", 32'(bus.o_mem_re), 32'd1);
                check("dump_addr_rd", bus.o_mem_addr, 32'd3);
                check("dump_we_rd", 32'(bus.o_mem_we), 32'd0);
            end
            if (probe && n == 11) begin
                check("stall_wait", 32'(bus.o_stall), 32'd1);
                check("re_wait", 32'(bus.o_mem_re), 32'd0);
            end
            if (probe && n == 12) begin
                clear_pipe();
                check("stalled_rdata", bus.o_data_read, 32'd0);
            end
            if (probe && n == 20) bus.i_dump_start = 1;
            if (bus.o_dump_valid && bus.o_dump_addr == 32'(hold_beat) && held < 3) begin
                bus.i_dump_ready = 0;
                held++;
                check("hold_data", bus.o_dump_data, model[hold_beat]);
            end else begin
                bus.i_dump_ready = 1;
            end
            if (bus.o_dump_valid && bus.i_dump_ready) begin
                if (sb_dump.size() == 0) begin
                    check("extra_beat", bus.o_dump_addr, 32'hFFFF_FFFF);
                end else begin
                    b = sb_dump.pop_front();
                    check("beat_addr", bus.o_dump_addr, b.addr);
                    check("beat_data", bus.o_dump_data, b.data);
                end
            end
            if (bus.o_dump_done) begin
                done_cnt++;
                check("done_cycle", 32'(n), 32'(exp_done));
            end
        end
        check("done_count", 32'(done_cnt), 32'd1);
        check("beats_left", 32'(sb_dump.size()), 32'd0);
        check("busy_after", 32'(bus.o_dump_busy), 32'd0);
        if (hold_beat >= 0) check("held_cycles", 32'(held), 32'd3);
    endtask

    initial begin
        rst_n = 0;
        reload = 0;
        clear_pipe();
        bus.i_dump_start = 0;
        bus.i_dump_ready = 0;
        do_reload();
        tick();
        check("rst_valid", 32'(bus.o_dump_valid), 32'd0);
        check("rst_busy", 32'(bus.o_dump_busy), 32'd0);
        check("rst_done", 32'(bus.o_dump_done), 32'd0);
        check("rst_ddata", bus.o_dump_data, 32'd0);
        check("rst_daddr", bus.o_dump_addr, 32'd0);
        check("rst_rdata", bus.o_data_read, 32'd0);
        check("rst_stall", 32'(bus.o_stall), 32'd0);
        check("rst_we", 32'(bus.o_mem_we), 32'd0);
        check("rst_re", 32'(bus.o_mem_re), 32'd0);
`ifdef DMEM_ADDR_CHECK_EN
        check("rst_err", 32'(bus.o_addr_err), 32'd0);
`endif
        rst_n = 1;
        tick();

        vecs[0] = mk(1, 0, 1, 32'd5,  32'hDEADBEEF, 1, 0, 0, 32'd5);
        vecs[1] = mk(1, 1, 0, 32'd5,  32'h0,        0, 1, 0, 32'd5);
        vecs[2] = mk(0, 1, 0, 32'd5,  32'h0,        0, 0, 0, 32'd5);
        vecs[3] = mk(1, 1, 1, 32'd3,  32'h12345678, 1, 0, 0, 32'd3);
        vecs[4] = mk(1, 1, 0, 32'd3,  32'h0,        0, 1, 0, 32'd3);
`ifdef DMEM_ADDR_CHECK_EN
        vecs[5] = mk(1, 0, 1, 32'd20, 32'hCAFEF00D, 0, 0, 1, 32'd20);
        vecs[8] = mk(1, 1, 0, 32'd17, 32'h0,        0, 0, 1, 32'd17);
`else
        vecs[5] = mk(1, 0, 1, 32'd20, 32'hCAFEF00D, 1, 0, 0, 32'd4);
        vecs[8] = mk(1, 1, 0, 32'd17, 32'h0,        0, 1, 0, 32'd1);
`endif
        vecs[6] = mk(1, 1, 0, 32'd4,  32'h0,        0, 1, 0, 32'd4);
        vecs[7] = mk(1, 1, 0, 32'd15, 32'h0,        0, 1, 0, 32'd15);
        vecs[9] = mk(0, 0, 1, 32'd7,  32'h55,       0, 0, 0, 32'd7);

        sb_rd.push_back(32'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("pipe_rdata", bus.o_data_read, sb_rd.pop_front());
            bus.i_step = vecs[i].step; bus.i_mem_read = vecs[i].rd; bus.i_mem_write = vecs[i].wr;
            bus.i_alu_address = vecs[i].addr; bus.i_data_reg = vecs[i].wdata;
            #1;
            check("pipe_we", 32'(bus.o_mem_we), 32'(vecs[i].exp_we));
            check("pipe_re", 32'(bus.o_mem_re), 32'(vecs[i].exp_re));
            check("pipe_addr", bus.o_mem_addr, vecs[i].exp_addr);
            check("pipe_stall", 32'(bus.o_stall), 32'd0);
`ifdef DMEM_ADDR_CHECK_EN
            check("pipe_err", 32'(bus.o_addr_err), 32'(vecs[i].exp_err));
`endif
            if (vecs[i].exp_we) model[vecs[i].exp_addr[3:0]] = vecs[i].wdata;
            sb_rd.push_back(vecs[i].exp_re ? model[vecs[i].exp_addr[3:0]] : 32'd0);
        end
        tick();
        check("pipe_rdata", bus.o_data_read, sb_rd.pop_front());
        clear_pipe();

        // Full dump with probes for stall and an ignored mid-dump start.
        do_reload();
        push_dump();
        bus.i_dump_start = 1;
        run_dump(-1, 49, 1);

        do_reload();
        push_dump();
        bus.i_dump_start = 1;
        run_dump(7, 52, 0);

        // Start coincides with a pipeline write: write first, dump follows.
        do_reload();
        bus.i_dump_start = 1;
        bus.i_step = 1; bus.i_mem_write = 1; bus.i_alu_address = 32'd2; bus.i_data_reg = 32'hA5A5_0002;
        #1;
        check("sim_we", 32'(bus.o_mem_we), 32'd1);
        check("sim_addr", bus.o_mem_addr, 32'd2);
        check("sim_stall", 32'(bus.o_stall), 32'd0);
        model[2] = 32'hA5A5_0002;
        push_dump();
        tick();
        bus.i_dump_start = 0;
        clear_pipe();
        #1;
        check("sim_pending_busy", 32'(bus.o_dump_busy), 32'd1);
        check("sim_no_re_yet", 32'(bus.o_mem_re), 32'd0);
        run_dump(-1, 49, 0);

        // Reset at beat 4 aborts the dump; a fresh start begins at address 0.
        do_reload();
        bus.i_dump_start = 1;
        bus.i_dump_ready = 1;
        for (int n = 0; n < 100 && !(bus.o_dump_valid && bus.o_dump_addr == 32'd4); n++) begin
            tick();
            bus.i_dump_start = 0;
        end
        check("reached_beat4", bus.o_dump_addr, 32'd4);
        rst_n = 0;
        #1;
        check("mid_rst_valid", 32'(bus.o_dump_valid), 32'd0);
        check("mid_rst_busy", 32'(bus.o_dump_busy), 32'd0);
        check("mid_rst_done", 32'(bus.o_dump_done), 32'd0);
        check("mid_rst_daddr", bus.o_dump_addr, 32'd0);
        check("mid_rst_re", 32'(bus.o_mem_re), 32'd0);
        tick();
        tick();
        rst_n = 1;
        for (int n = 0; n < 6; n++) begin
            tick();
            check("post_rst_done", 32'(bus.o_dump_done), 32'd0);
            check("post_rst_busy", 32'(bus.o_dump_busy), 32'd0);
        end
        sb_dump.delete();
        push_dump();
        bus.i_dump_start = 1;
        run_dump(-1, 49, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
